// File: rtl/plane_step_seq.sv
// plane_step_seq: serial plane-equation setup (shared restoring divider) followed by a
// 32x32 raster attribute stepper, one pixel per ready/valid handshake.
// Optional build macro PLANE_STEP_DEGEN_SKIP_EN: when the triangle determinant C is zero,
// flag degen and skip both divides (ddx = ddy = 0, every pixel equals fz1).
module plane_step_seq (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic [4:0]         frac_bits_i,
  input  logic signed [47:0] fx1_i,
  input  logic signed [47:0] fx2_i,
  input  logic signed [47:0] fx3_i,
  input  logic signed [47:0] fy1_i,
  input  logic signed [47:0] fy2_i,
  input  logic signed [47:0] fy3_i,
  input  logic signed [47:0] fz1_i,
  input  logic signed [47:0] fz2_i,
  input  logic signed [47:0] fz3_i,
  input  logic [10:0]        tile_x_i,
  input  logic [10:0]        tile_y_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic signed [31:0] out_value_o,
  output logic [4:0]         out_x_o,
  output logic [4:0]         out_y_o,
  output logic               out_last_o,
  output logic               degen_o
);
  typedef enum logic [2:0] {IDLE, DIFF, MUL, DIVX, DIVY, CONST, ROWINIT, STEP} state_e;
  state_e             state_q, state_d;
  logic [4:0]         frac_q;
  logic signed [47:0] fx1_q, fy1_q;
  logic signed [31:0] fx2_q, fx3_q, fy2_q, fy3_q, fz1_q, fz2_q, fz3_q;
  logic [10:0]        tx_q, ty_q;
  logic signed [31:0] dx2_q, dx3_q, dy2_q, dy3_q, dz2_q, dz3_q;
  logic signed [55:0] ba_q;
  logic signed [47:0] cden_q;
  logic [87:0]        quo_q;
  logic [48:0]        rem_q;
  logic [6:0]         cnt_q;
  logic               neg_q, degen_q;
  logic signed [31:0] ddx_q, ddy_q, c_q, row_q, acc_q;
  logic [4:0]         x_q, y_q;
  logic signed [63:0] pa1, pa2, pb1, pb2, pc1, pc2;
  logic signed [55:0] aa_w, ba_w, dsrc;
  logic signed [47:0] c_w;
  logic signed [87:0] dvd;
  logic [87:0]        dvd_mag, quo_n;
  logic               dneg, ge, skip, xfer, div_done;
  logic [47:0]        dvs_mag;
  logic [48:0]        trial, rem_n;
  logic signed [31:0] res_w, c_const, row_w;
  logic signed [79:0] kx, ky;

  // Cross products of the edge vectors, each rescaled back to the fixed-point format.
  assign pa1  = (64'(dz3_q) * 64'(dy2_q)) >>> frac_q;
  assign pa2  = (64'(dz2_q) * 64'(dy3_q)) >>> frac_q;
  assign pb1  = (64'(dx3_q) * 64'(dz2_q)) >>> frac_q;
  assign pb2  = (64'(dx2_q) * 64'(dz3_q)) >>> frac_q;
  assign pc1  = (64'(dx3_q) * 64'(dy2_q)) >>> frac_q;
  assign pc2  = (64'(dx2_q) * 64'(dy3_q)) >>> frac_q;
  assign aa_w = 56'(pa1 - pa2);
  assign ba_w = 56'(pb1 - pb2);
  assign c_w  = 48'(pc1 - pc2);

`ifdef PLANE_STEP_DEGEN_SKIP_EN
  assign skip = (c_w == 48'sd0);
`else
  assign skip = 1'b0;
`endif

  // Divider operand preparation: Aa is loaded at the end of MUL, Ba at the end of DIVX.
  assign dsrc    = (state_q == MUL) ? aa_w : ba_q;
  assign dvd     = 88'(dsrc) <<< frac_q;
  assign dvd_mag = dvd[87] ? 88'(-dvd) : 88'(dvd);
  assign dneg    = dsrc[55] ^ ((state_q == MUL) ? c_w[47] : cden_q[47]);
  assign dvs_mag = cden_q[47] ? 48'(-cden_q) : 48'(cden_q);

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign trial    = {rem_q[47:0], quo_q[87]};
  assign ge       = trial >= {1'b0, dvs_mag};
  assign rem_n    = ge ? trial - {1'b0, dvs_mag} : trial;
  assign quo_n    = {quo_q[86:0], ge};
  assign res_w    = (cden_q == 48'sd0) ? 32'sd0 : (neg_q ? -$signed(quo_n[31:0]) : $signed(quo_n[31:0]));
  assign div_done = (cnt_q == 7'd87);

  // Plane constant and the first row base of the tile.
  assign kx      = (80'(ddx_q) * 80'(fx1_q)) >>> frac_q;
  assign ky      = (80'(ddy_q) * 80'(fy1_q)) >>> frac_q;
  assign c_const = fz1_q - kx[31:0] - ky[31:0];
  assign row_w   = 32'(tx_q) * ddx_q + 32'(ty_q) * ddy_q + c_q;

  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == STEP);
  assign out_value_o = acc_q;
  assign out_x_o     = x_q;
  assign out_y_o     = y_q;
  assign out_last_o  = out_valid_o & (x_q == 5'd31) & (y_q == 5'd31);
  assign degen_o     = degen_q;
  assign xfer        = out_valid_o & out_ready_i;

  // Sequencing through setup phases and the pixel stream.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? DIFF : IDLE;
      DIFF:    state_d = MUL;
      MUL:     state_d = skip ? CONST : DIVX;
      DIVX:    state_d = div_done ? DIVY : DIVX;
      DIVY:    state_d = div_done ? CONST : DIVY;
      CONST:   state_d = ROWINIT;
      ROWINIT: state_d = STEP;
      STEP:    state_d = (xfer && out_last_o) ? IDLE : STEP;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Operand capture, setup datapath and raster stepping.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      frac_q  <= '0;
      fx1_q   <= '0;
      fy1_q   <= '0;
      fx2_q   <= '0;
      fx3_q   <= '0;
      fy2_q   <= '0;
      fy3_q   <= '0;
      fz1_q   <= '0;
      fz2_q   <= '0;
      fz3_q   <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      dx2_q   <= '0;
      dx3_q   <= '0;
      dy2_q   <= '0;
      dy3_q   <= '0;
      dz2_q   <= '0;
      dz3_q   <= '0;
      ba_q    <= '0;
      cden_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      degen_q <= 1'b0;
      ddx_q   <= '0;
      ddy_q   <= '0;
      c_q     <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          frac_q  <= frac_bits_i;
          fx1_q   <= fx1_i;
          fy1_q   <= fy1_i;
          fx2_q   <= fx2_i[31:0];
          fx3_q   <= fx3_i[31:0];
          fy2_q   <= fy2_i[31:0];
          fy3_q   <= fy3_i[31:0];
          fz1_q   <= fz1_i[31:0];
          fz2_q   <= fz2_i[31:0];
          fz3_q   <= fz3_i[31:0];
          tx_q    <= tile_x_i & 11'h7e0;
          ty_q    <= tile_y_i & 11'h7e0;
          ddx_q   <= '0;
          ddy_q   <= '0;
          degen_q <= 1'b0;
        end
        DIFF: begin
          dz3_q <= fz3_q - fz1_q;
          dz2_q <= fz2_q - fz1_q;
          dy2_q <= fy2_q - fy1_q[31:0];
          dy3_q <= fy3_q - fy1_q[31:0];
          dx2_q <= fx2_q - fx1_q[31:0];
          dx3_q <= fx3_q - fx1_q[31:0];
        end
        MUL: begin
          ba_q    <= ba_w;
          cden_q  <= c_w;
          degen_q <= skip;
          quo_q   <= dvd_mag;
          rem_q   <= '0;
          cnt_q   <= '0;
          neg_q   <= dneg;
        end
        DIVX, DIVY: begin
          quo_q <= div_done ? dvd_mag : quo_n;
          rem_q <= div_done ? '0 : rem_n;
          cnt_q <= div_done ? '0 : cnt_q + 7'd1;
          neg_q <= div_done ? dneg : neg_q;
          if (div_done && state_q == DIVX) ddx_q <= res_w;
          if (div_done && state_q == DIVY) ddy_q <= res_w;
        end
        CONST: c_q <= c_const;
        ROWINIT: begin
          row_q <= row_w;
          acc_q <= row_w;
          x_q   <= '0;
          y_q   <= '0;
        end
        STEP: if (xfer) begin
          if (x_q != 5'd31) begin
            acc_q <= acc_q + ddx_q;
            x_q   <= x_q + 5'd1;
          end else begin
            row_q <= row_q + ddy_q;
            acc_q <= row_q + ddy_q;
            x_q   <= 5'd0;
            y_q   <= y_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_plane_step_seq.sv
// tb_plane_step_seq: scenario tasks checked against a wide-integer model of the plane equations
module tb_plane_step_seq;
`ifdef PLANE_STEP_DEGEN_SKIP_EN
  localparam int   DEGEN_LAT = 4;
  localparam logic DEGEN_EXP = 1'b1;
`else
  localparam int   DEGEN_LAT = 180;
  localparam logic DEGEN_EXP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]         frac = '0;
  logic signed [47:0] fx1 = '0, fx2 = '0, fx3 = '0, fy1 = '0, fy2 = '0, fy3 = '0, fz1 = '0, fz2 = '0, fz3 = '0;
  logic [10:0]        tile_x = '0, tile_y = '0;
  logic               start = 1'b0, out_ready = 1'b0;
  logic               busy, out_valid, out_last, degen;
  logic signed [31:0] out_value;
  logic [4:0]         out_x, out_y;

  int tests = 0;
  int fails = 0;

  logic [31:0] cap_val[1024];
  logic [4:0]  cap_x[1024], cap_y[1024];
  logic        cap_last[1024];
  int          cap_n, first_valid, last_cyc, stall_err;
  logic        busy_after;
  logic [31:0] exp_val[1024];
  logic [31:0] m_ddx, m_ddy, m_c;

  plane_step_seq dut (
    .clock_i(clk), .reset_n_i(rst_n), .frac_bits_i(frac),
    .fx1_i(fx1), .fx2_i(fx2), .fx3_i(fx3), .fy1_i(fy1), .fy2_i(fy2), .fy3_i(fy3),
    .fz1_i(fz1), .fz2_i(fz2), .fz3_i(fz3), .tile_x_i(tile_x), .tile_y_i(tile_y),
    .start_i(start), .busy_o(busy), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_value_o(out_value), .out_x_o(out_x), .out_y_o(out_y), .out_last_o(out_last),
    .degen_o(degen)
  );

  function automatic logic signed [127:0] sx(input logic [127:0] v, input int w);
    logic signed [127:0] t;
    t = v << (128 - w);
    return t >>> (128 - w);
  endfunction

  task automatic compute_model();
    logic signed [127:0] dx2, dx3, dy2, dy3, dz2, dz3, aa, ba, cc, qx, qy, kx, ky;
    logic [31:0] tx, ty;
    int f;
    f   = int'(frac);
    dx2 = sx(128'(fx2 - fx1), 32);
    dx3 = sx(128'(fx3 - fx1), 32);
    dy2 = sx(128'(fy2 - fy1), 32);
    dy3 = sx(128'(fy3 - fy1), 32);
    dz2 = sx(128'(fz2 - fz1), 32);
    dz3 = sx(128'(fz3 - fz1), 32);
    aa  = sx(((dz3 * dy2) >>> f) - ((dz2 * dy3) >>> f), 56);
    ba  = sx(((dx3 * dz2) >>> f) - ((dx2 * dz3) >>> f), 56);
    cc  = sx(((dx3 * dy2) >>> f) - ((dx2 * dy3) >>> f), 48);
    qx  = (cc == 0) ? 128'sd0 : (aa <<< f) / cc;
    qy  = (cc == 0) ? 128'sd0 : (ba <<< f) / cc;
    m_ddx = qx[31:0];
    m_ddy = qy[31:0];
    kx  = (sx(128'(m_ddx), 32) * 128'(fx1)) >>> f;
    ky  = (sx(128'(m_ddy), 32) * 128'(fy1)) >>> f;
    m_c = fz1[31:0] - kx[31:0] - ky[31:0];
    tx  = 32'(tile_x & 11'h7e0);
    ty  = 32'(tile_y & 11'h7e0);
    for (int i = 0; i < 1024; i++)
      exp_val[i] = (tx + 32'(i % 32)) * m_ddx + (ty + 32'(i / 32)) * m_ddy + m_c;
  endtask

  task automatic rand_tri();
    frac   = 5'($urandom_range(0, 24));
    fx1    = 48'({$urandom, $urandom});
    fx2    = 48'({$urandom, $urandom});
    fx3    = 48'({$urandom, $urandom});
    fy1    = 48'({$urandom, $urandom});
    fy2    = 48'({$urandom, $urandom});
    fy3    = 48'({$urandom, $urandom});
    fz1    = 48'({$urandom, $urandom});
    fz2    = 48'({$urandom, $urandom});
    fz3    = 48'({$urandom, $urandom});
    tile_x = 11'($urandom);
    tile_y = 11'($urandom);
  endtask

  task automatic start_tile();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records pixels; k counts edges since the accepting edge E0 (sampled #1 after each edge).
  task automatic capture(input bit bp, input int stop_at, input int poke_at, input bit hold_start);
    int k;
    bit held;
    logic [42:0] hold_v;
    k = 0; held = 0; hold_v = '0;
    cap_n = 0; first_valid = -1; last_cyc = -1; stall_err = 0;
    while (cap_n < 1024 && k < 4000 && cap_n != stop_at) begin
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = (k == poke_at) || (hold_start && out_valid && out_ready && out_last);
      if (k == poke_at) begin
        fx1 = fx1 ^ 48'h0123_4567;
        fz2 = fz2 + 48'd999;
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = k;
        if (held && {out_value, out_x, out_y, out_last} !== hold_v) stall_err++;
        held = !out_ready;
        hold_v = {out_value, out_x, out_y, out_last};
        if (out_ready) begin
          cap_val[cap_n] = out_value;
          cap_x[cap_n] = out_x;
          cap_y[cap_n] = out_y;
          cap_last[cap_n] = out_last;
          if (out_last) last_cyc = k;
          cap_n++;
        end
      end
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b0;
    busy_after = busy;
  endtask

  function automatic int count_bad();
    int bad;
    bad = (cap_n == 1024) ? 0 : 1024 - cap_n;
    for (int i = 0; i < cap_n; i++) if (cap_val[i] !== exp_val[i]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, out_valid, out_last, degen} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl got busy/valid/last/degen=%b want 0000", {busy, out_valid, out_last, degen});
    end
    tests++;
    if ({out_value, out_x, out_y} !== 42'b0) begin
      fails++;
      $display("FAIL reset_data got value=%h x=%0d y=%0d want 0", out_value, out_x, out_y);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_flat();
    int bad, ord;
    frac = 5'd16;
    fx1 = 0; fy1 = 0; fx2 = 48'h20_0000; fy2 = 0; fx3 = 0; fy3 = 48'h20_0000;
    fz1 = 48'h1_0000; fz2 = 48'h1_0000; fz3 = 48'h1_0000;
    tile_x = 11'd64; tile_y = 11'd96;
    compute_model();
    start_tile();
    capture(0, -1, -1, 0);
    bad = (cap_n == 1024) ? 0 : 1;
    ord = 0;
    for (int i = 0; i < cap_n; i++) begin
      if (cap_val[i] !== 32'h1_0000) bad++;
      if (cap_x[i] !== 5'(i % 32) || cap_y[i] !== 5'(i / 32) || cap_last[i] !== (i == 1023)) ord++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL flat_values got %0d bad of %0d want 0 bad", bad, cap_n); end
    tests++;
    if (ord != 0) begin fails++; $display("FAIL flat_order got %0d misordered want 0", ord); end
    tests++;
    if (first_valid != 180) begin fails++; $display("FAIL flat_latency got %0d want 180", first_valid); end
    tests++;
    if (last_cyc != 1203) begin fails++; $display("FAIL flat_last_cycle got %0d want 1203", last_cyc); end
    tests++;
    if (busy_after !== 1'b0) begin fails++; $display("FAIL flat_busy_fall got %b want 0", busy_after); end
    tests++;
    if (degen !== 1'b0) begin fails++; $display("FAIL flat_degen got %b want 0", degen); end
  endtask

  task automatic test_ramp_backpressure();
    int bad, direct;
    frac = 5'd16;
    fx1 = 0; fy1 = 0; fx2 = 48'h20_0000; fy2 = 0; fx3 = 0; fy3 = 48'h20_0000;
    fz1 = 0; fz2 = 48'h20_0000; fz3 = 0;
    tile_x = 11'd32; tile_y = 11'd0;
    compute_model();
    start_tile();
    capture(1, -1, -1, 0);
    bad = count_bad();
    direct = 0;
    for (int i = 0; i < cap_n; i++) if (cap_val[i] !== 32'((32 + i % 32) << 16)) direct++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL ramp_model got %0d bad of %0d want 0", bad, cap_n); end
    tests++;
    if (direct != 0 || cap_n != 1024) begin fails++; $display("FAIL ramp_direct got %0d bad of %0d want 0", direct, cap_n); end
    tests++;
    if (stall_err != 0) begin fails++; $display("FAIL ramp_stall_stable got %0d changes want 0", stall_err); end
    tests++;
    if (busy_after !== 1'b0) begin fails++; $display("FAIL ramp_busy_fall got %b want 0", busy_after); end
    tests++;
    if (first_valid != 180) begin fails++; $display("FAIL ramp_latency got %0d want 180", first_valid); end
  endtask

  task automatic test_degen();
    int bad;
    frac = 5'd16;
    fx1 = 0; fy1 = 0; fx2 = 48'h1_0000; fy2 = 48'h1_0000; fx3 = 48'h2_0000; fy3 = 48'h2_0000;
    fz1 = 48'({$urandom, $urandom}); fz2 = 48'({$urandom, $urandom}); fz3 = 48'({$urandom, $urandom});
    tile_x = 11'($urandom); tile_y = 11'($urandom);
    compute_model();
    start_tile();
    capture(0, -1, -1, 0);
    bad = (cap_n == 1024) ? 0 : 1;
    for (int i = 0; i < cap_n; i++) if (cap_val[i] !== fz1[31:0]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL degen_values got %0d bad want 0 (fz1=%h)", bad, fz1[31:0]); end
    tests++;
    if (degen !== DEGEN_EXP) begin fails++; $display("FAIL degen_flag got %b want %b", degen, DEGEN_EXP); end
    tests++;
    if (first_valid != DEGEN_LAT) begin fails++; $display("FAIL degen_latency got %0d want %0d", first_valid, DEGEN_LAT); end
  endtask

  task automatic test_reset_mid();
    int bad;
    rand_tri();
    compute_model();
    start_tile();
    capture(0, 500, -1, 0);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (cap_n != 500 || {busy, out_valid, out_last, degen, out_value, out_x, out_y} !== 46'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs got n=%0d busy=%b valid=%b last=%b value=%h x=%0d y=%0d want 500 and all 0",
               cap_n, busy, out_valid, out_last, out_value, out_x, out_y);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rand_tri();
    compute_model();
    start_tile();
    capture(1, -1, -1, 0);
    bad = count_bad();
    tests++;
    if (bad != 0) begin fails++; $display("FAIL reset_mid_retile got %0d bad of %0d want 0", bad, cap_n); end
  endtask

  task automatic test_start_busy();
    int bad;
    rand_tri();
    compute_model();
    start_tile();
    capture(0, -1, 50, 0);
    bad = count_bad();
    tests++;
    if (bad != 0) begin fails++; $display("FAIL start_busy_values got %0d bad of %0d want 0", bad, cap_n); end
  endtask

  task automatic test_back_to_back();
    int bad;
    rand_tri();
    compute_model();
    start_tile();
    capture(0, -1, -1, 1);
    bad = count_bad();
    tests++;
    if (bad != 0) begin fails++; $display("FAIL b2b_first got %0d bad of %0d want 0", bad, cap_n); end
    tests++;
    if (busy_after !== 1'b0) begin fails++; $display("FAIL b2b_start_at_last got busy=%b want 0", busy_after); end
    rand_tri();
    compute_model();
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept_next got busy=%b want 1", busy); end
    capture(1, -1, -1, 0);
    bad = count_bad();
    tests++;
    if (bad != 0 || first_valid != 180) begin
      fails++;
      $display("FAIL b2b_second got %0d bad latency %0d want 0 bad latency 180", bad, first_valid);
    end
  endtask

  task automatic test_random();
    int bad;
    for (int t = 0; t < 3; t++) begin
      rand_tri();
      compute_model();
      start_tile();
      capture(t != 0, -1, -1, 0);
      bad = count_bad();
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL random_%0d got %0d bad of %0d want 0 (ddx=%h ddy=%h c=%h)", t, bad, cap_n, m_ddx, m_ddy, m_c);
      end
      tests++;
      if (stall_err != 0) begin fails++; $display("FAIL random_stall_%0d got %0d changes want 0", t, stall_err); end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_ramp_backpressure();
    test_degen();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
